sdu_top: RTL and testbench

SDU_TOP -- requirements
Module: sdu_top

---
 rtl/sdu_top.sv | 191 +++++++++++++++++++
 tb/tb_sdu_top.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdu_top.sv
// Sample decimator + 128-point in-place radix-2 DIT FFT; 448-cycle compute, results streamed on unload.
// Backpressure: fir_filter_rfd_Ff drops outside LOAD, new data is only taken while it is high.
module sdu_top #(
  parameter int DECIM  = 7,
  parameter int NPRIME = 106
) (
  input  logic               fast_clk,
  input  logic               reset,
  input  logic signed [15:0] din_re_Ff,
  input  logic signed [15:0] din_im_Ff,
  input  logic               fir_filter_nd_Ff,
  output logic               fir_filter_rfd_Ff,
  output logic               fft_done_Fs,
  input  logic               fft_unload_Fs,
  output logic               fft_dv_Fs,
  output logic signed [31:0] dout_re_Fs,
  output logic signed [31:0] dout_im_Fs
);

  localparam int PW = (NPRIME < 1) ? 1 : $clog2(NPRIME + 1);
  localparam int DW = (DECIM < 2) ? 1 : $clog2(DECIM);

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_DONE, S_UNLOAD} state_t;

  state_t                state, state_nxt;
  logic [PW-1:0]         prime_cnt;
  logic [DW-1:0]         dec_cnt;
  logic signed [18:0]    acc_re, acc_im, sum_re, sum_im;
  logic [6:0]            samp_idx;
  logic [2:0]            stg;
  logic [5:0]            bf;
  logic [6:0]            out_idx;
  logic                  accept, primed, dec_last, frame_full, bf_last;

  logic signed [31:0]    mem_re [0:127];
  logic signed [31:0]    mem_im [0:127];

  function automatic logic [6:0] bitrev7(input logic [6:0] v);
    logic [6:0] r;
    for (int i = 0; i < 7; i++) r[i] = v[6-i];
    return r;
  endfunction

  // Quarter-wave table: round(32767*cos(pi*i/64)), i = 0..32
  function automatic logic signed [15:0] qcos(input logic [5:0] i);
    case (i)
      6'd0:  return 16'sd32767;  6'd1:  return 16'sd32728;  6'd2:  return 16'sd32609;
      6'd3:  return 16'sd32412;  6'd4:  return 16'sd32137;  6'd5:  return 16'sd31785;
      6'd6:  return 16'sd31356;  6'd7:  return 16'sd30852;  6'd8:  return 16'sd30273;
      6'd9:  return 16'sd29621;  6'd10: return 16'sd28898;  6'd11: return 16'sd28105;
      6'd12: return 16'sd27245;  6'd13: return 16'sd26319;  6'd14: return 16'sd25329;
      6'd15: return 16'sd24279;  6'd16: return 16'sd23170;  6'd17: return 16'sd22005;
      6'd18: return 16'sd20787;  6'd19: return 16'sd19519;  6'd20: return 16'sd18204;
      6'd21: return 16'sd16846;  6'd22: return 16'sd15446;  6'd23: return 16'sd14010;
      6'd24: return 16'sd12539;  6'd25: return 16'sd11039;  6'd26: return 16'sd9512;
      6'd27: return 16'sd7962;   6'd28: return 16'sd6393;   6'd29: return 16'sd4808;
      6'd30: return 16'sd3212;   6'd31: return 16'sd1608;
      default: return 16'sd0;
    endcase
  endfunction

  // 64-entry twiddle ROM folded from the quarter wave; returns {cos, -sin}
  function automatic logic [31:0] twiddle(input logic [5:0] k);
    logic signed [15:0] c, s;
    if (k <= 6'd32) begin
      c = qcos(k);
      s = qcos(6'd32 - k);
    end else begin
      c = -qcos(6'(7'd64 - {1'b0, k}));
      s = qcos(k - 6'd32);
    end
    return {c, -s};
  endfunction

  assign accept     = fir_filter_nd_Ff && (state == S_LOAD);
  assign primed     = (prime_cnt == PW'(NPRIME));
  assign sum_re     = acc_re + 19'(din_re_Ff);
  assign sum_im     = acc_im + 19'(din_im_Ff);
  assign dec_last   = accept && primed && (dec_cnt == DW'(DECIM - 1));
  assign frame_full = dec_last && (samp_idx == 7'd127);
  assign bf_last    = (stg == 3'd6) && (bf == 6'd63);

  // Butterfly addressing for stage stg (span = 2^stg)
  logic [6:0]         bf7, mask7, span7, top, bot;
  logic [5:0]         tw_k;
  logic signed [15:0] w_re, w_im;
  logic signed [31:0] a_re, a_im, b_re, b_im, t_re, t_im;
  logic signed [47:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [48:0] t_re_full, t_im_full;

  assign bf7   = {1'b0, bf};
  assign span7 = 7'd1 << stg;
  assign mask7 = span7 - 7'd1;
  assign top   = ((bf7 >> stg) << (stg + 3'd1)) | (bf7 & mask7);
  assign bot   = top | span7;
  assign tw_k  = 6'((bf7 & mask7) << (3'd6 - stg));
  assign {w_re, w_im} = twiddle(tw_k);

  assign a_re = mem_re[top];
  assign a_im = mem_im[top];
  assign b_re = mem_re[bot];
  assign b_im = mem_im[bot];

  assign p_rr = 48'(b_re) * 48'(w_re);
  assign p_ii = 48'(b_im) * 48'(w_im);
  assign p_ri = 48'(b_re) * 48'(w_im);
  assign p_ir = 48'(b_im) * 48'(w_re);
  assign t_re_full = 49'(p_rr) - 49'(p_ii);
  assign t_im_full = 49'(p_ri) + 49'(p_ir);
  assign t_re = (tw_k == 6'd0) ? b_re : 32'(t_re_full >>> 15);
  assign t_im = (tw_k == 6'd0) ? b_im : 32'(t_im_full >>> 15);

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) state <= S_LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    fir_filter_rfd_Ff = 1'b0;
    fft_done_Fs       = 1'b0;
    case (state)
      S_LOAD: begin
        fir_filter_rfd_Ff = 1'b1;
        if (frame_full) state_nxt = S_COMPUTE;
      end
      S_COMPUTE: if (bf_last) state_nxt = S_DONE;
      S_DONE: begin
        fft_done_Fs = 1'b1;
        if (fft_unload_Fs) state_nxt = S_UNLOAD;
      end
      S_UNLOAD: if (out_idx == 7'd127) state_nxt = S_LOAD;
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      prime_cnt  <= '0;
      dec_cnt    <= '0;
      acc_re     <= '0;
      acc_im     <= '0;
      samp_idx   <= '0;
      stg        <= '0;
      bf         <= '0;
      out_idx    <= '0;
      fft_dv_Fs  <= 1'b0;
      dout_re_Fs <= '0;
      dout_im_Fs <= '0;
    end else begin
      if (accept) begin
        if (!primed) begin
          prime_cnt <= prime_cnt + PW'(1);
        end else if (dec_last) begin
          acc_re   <= '0;
          acc_im   <= '0;
          dec_cnt  <= '0;
          samp_idx <= samp_idx + 7'd1;
        end else begin
          acc_re  <= sum_re;
          acc_im  <= sum_im;
          dec_cnt <= dec_cnt + DW'(1);
        end
      end
      if (state == S_COMPUTE) begin
        bf <= bf + 6'd1;
        if (bf == 6'd63) stg <= (stg == 3'd6) ? 3'd0 : stg + 3'd1;
      end
      fft_dv_Fs <= (state == S_UNLOAD);
      if (state == S_UNLOAD) begin
        dout_re_Fs <= mem_re[out_idx];
        dout_im_Fs <= mem_im[out_idx];
        out_idx    <= out_idx + 7'd1;
      end
    end
  end

  // Frame memory is not reset; a frame is fully rewritten before it is transformed
  always_ff @(posedge fast_clk) begin
    if (dec_last) begin
      mem_re[bitrev7(samp_idx)] <= 32'(sum_re);
      mem_im[bitrev7(samp_idx)] <= 32'(sum_im);
    end else if (state == S_COMPUTE) begin
      mem_re[top] <= a_re + t_re;
      mem_im[top] <= a_im + t_im;
      mem_re[bot] <= a_re - t_re;
      mem_im[bot] <= a_im - t_im;
    end
  end

endmodule

// File: tb/tb_sdu_top.sv
// Randomised and directed frames against a loop-based reference FFT model.
module tb_sdu_top;

  localparam int DECIM  = 7;
  localparam int NPRIME = 106;

  logic               fast_clk = 1'b0;
  logic               reset;
  logic signed [15:0] din_re, din_im;
  logic               nd, rfd, done, unload, dv;
  logic signed [31:0] dout_re, dout_im;

  sdu_top #(.DECIM(DECIM), .NPRIME(NPRIME)) dut (
    .fast_clk          (fast_clk),
    .reset             (reset),
    .din_re_Ff         (din_re),
    .din_im_Ff         (din_im),
    .fir_filter_nd_Ff  (nd),
    .fir_filter_rfd_Ff (rfd),
    .fft_done_Fs       (done),
    .fft_unload_Fs     (unload),
    .fft_dv_Fs         (dv),
    .dout_re_Fs        (dout_re),
    .dout_im_Fs        (dout_im)
  );

  always #5 fast_clk = ~fast_clk;

  int total, bad, gap_max;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model state
  int     prime_left, dcnt, nidx;
  longint acc_re, acc_im;
  int     dec_re [128], dec_im [128];
  int     exp_re [128], exp_im [128];

  function automatic int rnd(input real x);
    return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
  endfunction

  task automatic model_reset();
    prime_left = NPRIME;
    dcnt = 0; nidx = 0; acc_re = 0; acc_im = 0;
  endtask

  task automatic model_fft();
    int a_re [128], a_im [128];
    real pi = 3.14159265358979;
    for (int n = 0; n < 128; n++) begin
      int r = 0;
      for (int b = 0; b < 7; b++) if (((n >> b) & 1) != 0) r |= 1 << (6 - b);
      a_re[r] = dec_re[n];
      a_im[r] = dec_im[n];
    end
    for (int len = 2; len <= 128; len *= 2) begin
      int half = len / 2;
      for (int start = 0; start < 128; start += len) begin
        for (int j = 0; j < half; j++) begin
          int k = j * (128 / len);
          int wr = rnd(32767.0 * $cos(2.0 * pi * k / 128.0));
          int wi = -rnd(32767.0 * $sin(2.0 * pi * k / 128.0));
          int p = start + j, q = start + j + half;
          int tr, ti;
          if (k == 0) begin
            tr = a_re[q]; ti = a_im[q];
          end else begin
            tr = int'((longint'(a_re[q]) * wr - longint'(a_im[q]) * wi) >>> 15);
            ti = int'((longint'(a_re[q]) * wi + longint'(a_im[q]) * wr) >>> 15);
          end
          a_re[q] = a_re[p] - tr; a_im[q] = a_im[p] - ti;
          a_re[p] = a_re[p] + tr; a_im[p] = a_im[p] + ti;
        end
      end
    end
    for (int n = 0; n < 128; n++) begin
      exp_re[n] = a_re[n];
      exp_im[n] = a_im[n];
    end
  endtask

  task automatic model_absorb(input int re, input int im);
    if (prime_left > 0) begin
      prime_left--;
      return;
    end
    acc_re += re; acc_im += im; dcnt++;
    if (dcnt == DECIM) begin
      dec_re[nidx] = int'(acc_re); dec_im[nidx] = int'(acc_im);
      acc_re = 0; acc_im = 0; dcnt = 0; nidx++;
      if (nidx == 128) begin
        model_fft();
        nidx = 0;
      end
    end
  endtask

  task automatic send(input int re, input int im);
    int t = 0;
    nd = 1'b0;
    repeat ($urandom_range(0, gap_max)) @(negedge fast_clk);
    while (!rfd && t < 3000) begin
      @(negedge fast_clk);
      t++;
    end
    if (!rfd) begin
      check("rfd_wait", rfd, 1);
      return;
    end
    din_re = 16'(re); din_im = 16'(im); nd = 1'b1;
    @(posedge fast_clk);
    model_absorb(re, im);
    @(negedge fast_clk);
    nd = 1'b0;
  endtask

  task automatic send_n(input int n, input int re, input int im);
    for (int i = 0; i < n; i++) send(re, im);
  endtask

  task automatic send_rand(input int n);
    logic signed [15:0] r16, i16;
    for (int i = 0; i < n; i++) begin
      r16 = 16'($urandom); i16 = 16'($urandom);
      send(int'(r16), int'(i16));
    end
  endtask

  task automatic set_exp(input int bin0, input int others);
    for (int n = 0; n < 128; n++) begin
      exp_re[n] = (n == 0) ? bin0 : others;
      exp_im[n] = 0;
    end
  endtask

  task automatic collect(input string tag);
    int t = 0;
    while (!done && t < 3000) begin
      @(negedge fast_clk);
      t++;
    end
    check({tag, "_done"}, done, 1);
    unload = 1'b1;
    @(negedge fast_clk);
    unload = 1'b0;
    t = 0;
    while (!dv && t < 4) begin
      @(negedge fast_clk);
      t++;
    end
    for (int i = 0; i < 128; i++) begin
      check($sformatf("%s_dv[%0d]", tag, i), dv, 1);
      check($sformatf("%s_re[%0d]", tag, i), dout_re, exp_re[i]);
      check($sformatf("%s_im[%0d]", tag, i), dout_im, exp_im[i]);
      @(negedge fast_clk);
    end
    check({tag, "_dv_end"}, dv, 0);
    check({tag, "_rfd_end"}, rfd, 1);
    @(negedge fast_clk);
    check({tag, "_hold_re"}, dout_re, exp_re[127]);
    check({tag, "_hold_im"}, dout_im, exp_im[127]);
  endtask

  initial begin
    int t, cnt_a, cnt_b;
    total = 0; bad = 0; gap_max = 2;
    nd = 1'b0; unload = 1'b0; din_re = '0; din_im = '0; reset = 1'b0;
    model_reset();

    repeat (10) @(negedge fast_clk);
    check("rst_rfd", rfd, 1);
    check("rst_done", done, 0);
    check("rst_dv", dv, 0);
    check("rst_dout_re", dout_re, 0);
    check("rst_dout_im", dout_im, 0);
    reset = 1'b1;
    repeat (5) @(negedge fast_clk);
    check("idle_rfd", rfd, 1);
    check("idle_done", done, 0);
    check("idle_dv", dv, 0);
    check("idle_dout_re", dout_re, 0);

    // DC frame with handshake probing during COMPUTE/DONE
    send_n(NPRIME, 0, 0);
    send_n(896, 1, 0);
    check("rfd_compute", rfd, 0);
    din_re = 16'sd1234; din_im = -16'sd77; nd = 1'b1; unload = 1'b1;
    @(negedge fast_clk);
    unload = 1'b0;
    cnt_a = 0; cnt_b = 0;
    repeat (20) begin
      @(negedge fast_clk);
      cnt_a += int'(dv);
      cnt_b += int'(rfd);
    end
    check("early_unload_dv", cnt_a, 0);
    check("rfd_low_compute", cnt_b, 0);
    t = 0;
    while (!done && t < 1000) begin
      @(negedge fast_clk);
      t++;
    end
    check("dc_done_seen", done, 1);
    cnt_a = 0; cnt_b = 0;
    repeat (10) begin
      @(negedge fast_clk);
      cnt_a += int'(done);
      cnt_b += int'(rfd) + int'(dv);
    end
    check("done_held", cnt_a, 10);
    check("rfd_dv_low_done", cnt_b, 0);
    nd = 1'b0;
    set_exp(896, 0);
    collect("dc");

    // Random frame with compute-latency check
    send_rand(896);
    t = 0;
    while (!done && t < 1000) begin
      @(negedge fast_clk);
      t++;
    end
    check("compute_cycles", t, 448);
    collect("rnd");

    // Random frame aborted by reset mid-compute
    send_rand(896);
    repeat (100) @(negedge fast_clk);
    reset = 1'b0;
    #1;
    check("abort_rfd", rfd, 1);
    check("abort_done", done, 0);
    @(negedge fast_clk);
    @(negedge fast_clk);
    reset = 1'b1;
    model_reset();
    cnt_a = 0;
    repeat (600) begin
      @(negedge fast_clk);
      cnt_a += int'(done);
    end
    check("abort_done_never", cnt_a, 0);
    check("abort_rfd_after", rfd, 1);

    // Priming discard after the abort
    send_n(NPRIME, 1000, -1000);
    send_n(896, 0, 0);
    set_exp(0, 0);
    collect("prime");

    // Impulse after a fresh reset, back-to-back samples
    @(negedge fast_clk);
    reset = 1'b0;
    @(negedge fast_clk);
    reset = 1'b1;
    model_reset();
    gap_max = 0;
    send_n(NPRIME, 0, 0);
    send_n(DECIM, 1, 0);
    send_n(896 - DECIM, 0, 0);
    set_exp(7, 7);
    collect("imp");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
